// File: rtl/io_port_pkg.sv
// Shared constants and payload types for the Lynx 128 I/O-space responder.
package io_port_pkg;

    localparam logic [7:0] PORT_BANK  = 8'h7F;
    localparam logic [7:0] PORT_VIDEO = 8'h80;
    localparam logic [7:0] IM1_VECTOR = 8'hFF;

    localparam int unsigned IRQ_PERIOD_DEF = 69888;
    localparam int unsigned IRQ_WIDTH_DEF  = 32;

    // Read-side qualifiers captured on one ne tick and consumed on the next.
    typedef struct packed {
        logic       rd_ok;
        logic [7:0] port;
        logic [7:0] kbd;
    } rd_stage_t;

endpackage

// File: rtl/io_port_if.sv
// CPU-side I/O bus: active-low strobes, address and data in both directions.
interface io_port_if;
    logic        iorq;
    logic        m1;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  q;
    logic        irq;

    modport master (output iorq, m1, rd, wr, a, d, input  q, irq);
    modport slave  (input  iorq, m1, rd, wr, a, d, output q, irq);
endinterface

// File: rtl/io_port_irq_timer.sv
// Frame interrupt generator: periodic assertion, bounded width, release on acknowledge.
module io_port_irq_timer
    import io_port_pkg::*;
#(
    parameter int unsigned IRQ_PERIOD = IRQ_PERIOD_DEF,
    parameter int unsigned IRQ_WIDTH  = IRQ_WIDTH_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic ne,
    input  logic ack,
    output logic irq
);

    localparam int unsigned CNT_W = (IRQ_PERIOD > 1) ? $clog2(IRQ_PERIOD) : 1;
    localparam int unsigned W_W   = (IRQ_WIDTH > 1) ? $clog2(IRQ_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IRQ_PERIOD - 1);
    localparam logic [W_W-1:0]   W_LOAD   = W_W'(IRQ_WIDTH - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [W_W-1:0]   w, w_nxt;
    logic             irq_nxt;

    // Next-state: wrap re-arms the pulse and outranks acknowledge on the same tick.
    always_comb begin
        cnt_nxt = cnt;
        w_nxt   = w;
        irq_nxt = irq;
        if (ne) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt = '0;
                irq_nxt = 1'b0;
                w_nxt   = W_LOAD;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
                if (!irq) begin
                    if (ack || (w == '0)) begin
                        irq_nxt = 1'b1;
                    end else begin
                        w_nxt = w - W_W'(1);
                    end
                end
            end
        end
    end

    // State registers; reset releases irq immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            w   <= '0;
            irq <= 1'b1;
        end else begin
            cnt <= cnt_nxt;
            w   <= w_nxt;
            irq <= irq_nxt;
        end
    end

endmodule

// File: rtl/io_port.sv
// Z80 I/O-space responder: bank/video registers, keyboard read, frame interrupt.
module io_port
    import io_port_pkg::*;
#(
    parameter int unsigned IRQ_PERIOD = IRQ_PERIOD_DEF,
    parameter int unsigned IRQ_WIDTH  = IRQ_WIDTH_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ne,
    io_port_if.slave   bus,
    output logic [7:0] bank,
    output logic [7:0] video,
    output logic [3:0] kbd_row,
    input  logic [7:0] kbd
);

    logic      wr_act;
    logic      rd_act;
    logic      ack_act;
    logic      wr_prev;
    logic      wr_fire;
    rd_stage_t stage;
    logic [7:0] q_r;
    logic      irq_w;
    logic      unused_addr;

    // Upper address nibble plays no part in decode or row select.
    assign unused_addr = ^bus.a[15:12];

    // Row select follows the address directly so it is stable for the whole read.
    assign kbd_row = bus.a[11:8];

    // Cycle-type decode from the raw active-low strobes.
    always_comb begin
        wr_act  = ~bus.iorq & ~bus.wr & bus.m1;
        rd_act  = ~bus.iorq & ~bus.rd & bus.m1;
        ack_act = ~bus.iorq & ~bus.m1;
        wr_fire = wr_act & ~wr_prev;
    end

    // Bus registers: one-shot writes, one-tick-delayed read data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_prev <= 1'b0;
            stage   <= '0;
            q_r     <= IM1_VECTOR;
            bank    <= 8'h00;
            video   <= 8'h00;
        end else if (ne) begin
            wr_prev <= wr_act;
            stage   <= '{rd_ok: rd_act & ~wr_act, port: bus.a[7:0], kbd: kbd};
            if (stage.rd_ok && (stage.port == PORT_VIDEO)) begin
                q_r <= stage.kbd;
            end else begin
                q_r <= IM1_VECTOR;
            end
            if (wr_fire) begin
                case (bus.a[7:0])
                    PORT_BANK:  bank  <= bus.d;
                    PORT_VIDEO: video <= bus.d;
                    default:    ;
                endcase
            end
        end
    end

    io_port_irq_timer #(
        .IRQ_PERIOD (IRQ_PERIOD),
        .IRQ_WIDTH  (IRQ_WIDTH)
    ) u_irq_timer (
        .clock (clock),
        .reset (reset),
        .ne    (ne),
        .ack   (ack_act),
        .irq   (irq_w)
    );

    assign bus.q   = q_r;
    assign bus.irq = irq_w;

endmodule

// File: tb/tb_io_port.sv
// Bench for io_port: vector table, directed interrupt/reset sequences, random vs model.
module tb_io_port;

    localparam int P = 200;
    localparam int W = 8;

    logic       clock;
    logic       reset;
    logic       ne;
    logic [7:0] kbd;
    logic [7:0] bank;
    logic [7:0] video;
    logic [3:0] kbd_row;

    io_port_if bus();

    io_port #(.IRQ_PERIOD(P), .IRQ_WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .ne      (ne),
        .bus     (bus),
        .bank    (bank),
        .video   (video),
        .kbd_row (kbd_row),
        .kbd     (kbd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        iorq;
        logic        m1;
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  kb;
        logic [7:0]  eq;
        logic [7:0]  ebank;
        logic [7:0]  evideo;
        logic [3:0]  erow;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic iorq, input logic m1, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [7:0] d, input logic [7:0] kb,
                       input logic [7:0] eq, input logic [7:0] eb, input logic [7:0] ev,
                       input logic [3:0] er);
        vec_t v;
        v = '{iorq, m1, rd, wr, a, d, kb, eq, eb, ev, er};
        vq.push_back(v);
    endtask

    task automatic set_bus(input logic iorq, input logic m1, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [7:0] d);
        bus.iorq = iorq;
        bus.m1   = m1;
        bus.rd   = rd;
        bus.wr   = wr;
        bus.a    = a;
        bus.d    = d;
    endtask

    task automatic idle();
        set_bus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
    endtask

    task automatic tick(input logic ne_v);
        ne = ne_v;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        repeat (3) tick(1'b1);
        reset = 1'b1;
    endtask

    // Reference model state, advanced once per ne tick.
    bit         m_prev_wr;
    bit         m_st_rd;
    logic [7:0] m_st_port;
    logic [7:0] m_st_kbd;
    logic [7:0] m_q, m_bank, m_video;
    int         m_t, m_start;
    bit         m_acked;

    function automatic logic m_irq();
        return (m_start > 0 && (m_t - m_start) < W && !m_acked) ? 1'b0 : 1'b1;
    endfunction

    task automatic model_reset();
        m_prev_wr = 0; m_st_rd = 0; m_st_port = 8'h00; m_st_kbd = 8'h00;
        m_q = 8'hFF; m_bank = 8'h00; m_video = 8'h00;
        m_t = 0; m_start = 0; m_acked = 0;
    endtask

    task automatic model_tick();
        bit wr_a, rd_a, ack_a;
        wr_a  = !bus.iorq && !bus.wr && bus.m1;
        rd_a  = !bus.iorq && !bus.rd && bus.m1;
        ack_a = !bus.iorq && !bus.m1;
        m_q = (m_st_rd && m_st_port == 8'h80) ? m_st_kbd : 8'hFF;
        if (wr_a && !m_prev_wr) begin
            if (bus.a[7:0] == 8'h7F) m_bank = bus.d;
            else if (bus.a[7:0] == 8'h80) m_video = bus.d;
        end
        m_prev_wr = wr_a;
        m_st_rd   = rd_a && !wr_a;
        m_st_port = bus.a[7:0];
        m_st_kbd  = kbd;
        m_t++;
        if (m_t % P == 0) begin
            m_start = m_t;
            m_acked = 0;
        end else if (ack_a) begin
            m_acked = 1;
        end
    endtask

    initial begin
        reset = 1'b0;
        ne    = 1'b0;
        kbd   = 8'hFF;
        idle();

        // Reset held while the bus toggles.
        for (int i = 0; i < 4; i++) begin
            set_bus(1'(i & 1), 1'b1, 1'b0, 1'(i >> 1), 16'h007F + 16'(i), 8'hA5);
            tick(1'b1);
        end
        chk("rst_q", 16'(bus.q), 16'h00FF);
        chk("rst_irq", 16'(bus.irq), 16'h0001);
        chk("rst_bank", 16'(bank), 16'h0000);
        chk("rst_video", 16'(video), 16'h0000);
        idle();
        reset = 1'b1;

        // Vector table: one ne tick per record.
        add(1,1,1,1,16'h0000,8'h00,8'hFF, 8'hFF,8'h00,8'h00,4'h0);
        add(0,1,1,0,16'h007F,8'h5A,8'hFF, 8'hFF,8'h5A,8'h00,4'h0);
        add(0,1,1,0,16'h007F,8'h11,8'hFF, 8'hFF,8'h5A,8'h00,4'h0);
        add(0,1,1,0,16'h007F,8'h11,8'hFF, 8'hFF,8'h5A,8'h00,4'h0);
        add(0,1,1,0,16'h007F,8'h11,8'hFF, 8'hFF,8'h5A,8'h00,4'h0);
        add(1,1,1,1,16'h0000,8'h00,8'hFF, 8'hFF,8'h5A,8'h00,4'h0);
        add(0,1,1,0,16'h0080,8'h3C,8'hFF, 8'hFF,8'h5A,8'h3C,4'h0);
        add(0,1,1,0,16'h0080,8'h77,8'hFF, 8'hFF,8'h5A,8'h3C,4'h0);
        add(0,1,1,0,16'h0080,8'h77,8'hFF, 8'hFF,8'h5A,8'h3C,4'h0);
        add(0,1,1,0,16'h0080,8'h77,8'hFF, 8'hFF,8'h5A,8'h3C,4'h0);
        add(1,1,1,1,16'h0000,8'h00,8'hFF, 8'hFF,8'h5A,8'h3C,4'h0);
        add(0,1,1,0,16'h0010,8'h99,8'hFF, 8'hFF,8'h5A,8'h3C,4'h0);
        add(0,1,1,0,16'h0010,8'h99,8'hFF, 8'hFF,8'h5A,8'h3C,4'h0);
        add(1,1,1,1,16'h0000,8'h00,8'hFF, 8'hFF,8'h5A,8'h3C,4'h0);
        add(0,1,0,1,16'h0780,8'h00,8'hEF, 8'hFF,8'h5A,8'h3C,4'h7);
        add(0,1,0,1,16'h0780,8'h00,8'hEF, 8'hEF,8'h5A,8'h3C,4'h7);
        add(1,1,1,1,16'h0000,8'h00,8'h00, 8'hEF,8'h5A,8'h3C,4'h0);
        add(0,1,0,1,16'h0311,8'h00,8'h00, 8'hFF,8'h5A,8'h3C,4'h3);
        add(0,1,0,1,16'h0311,8'h00,8'h00, 8'hFF,8'h5A,8'h3C,4'h3);
        add(1,1,1,1,16'h0000,8'h00,8'h00, 8'hFF,8'h5A,8'h3C,4'h0);
        add(0,1,0,0,16'h0580,8'h42,8'h00, 8'hFF,8'h5A,8'h42,4'h5);
        add(0,1,0,0,16'h0580,8'h42,8'h00, 8'hFF,8'h5A,8'h42,4'h5);
        add(1,1,1,1,16'h0000,8'h00,8'h00, 8'hFF,8'h5A,8'h42,4'h0);
        add(0,0,0,1,16'h0080,8'h00,8'h12, 8'hFF,8'h5A,8'h42,4'h0);
        add(0,0,0,1,16'h0080,8'h00,8'h12, 8'hFF,8'h5A,8'h42,4'h0);
        add(1,1,1,1,16'h0000,8'h00,8'h00, 8'hFF,8'h5A,8'h42,4'h0);

        foreach (vq[i]) begin
            set_bus(vq[i].iorq, vq[i].m1, vq[i].rd, vq[i].wr, vq[i].a, vq[i].d);
            kbd = vq[i].kb;
            tick(1'b1);
            chk($sformatf("vec%0d_q", i), 16'(bus.q), 16'(vq[i].eq));
            chk($sformatf("vec%0d_bank", i), 16'(bank), 16'(vq[i].ebank));
            chk($sformatf("vec%0d_video", i), 16'(video), 16'(vq[i].evideo));
            chk($sformatf("vec%0d_row", i), 16'(kbd_row), 16'(vq[i].erow));
        end

        // Unacknowledged pulses at P and 2P, each W ticks wide.
        do_reset();
        for (int t = 1; t <= 2 * P + 2; t++) begin
            logic exp_irq;
            tick(1'b1);
            exp_irq = ((t >= P && t < P + W) || (t >= 2 * P && t < 2 * P + W)) ? 1'b0 : 1'b1;
            chk($sformatf("irq_t%0d", t), 16'(bus.irq), 16'(exp_irq));
        end
        // Acknowledge on the third tick of the pulse releases it.
        set_bus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00);
        tick(1'b1);
        chk("ack_irq", 16'(bus.irq), 16'h0001);
        chk("ack_q0", 16'(bus.q), 16'h00FF);
        idle();
        tick(1'b1);
        chk("ack_q1", 16'(bus.q), 16'h00FF);
        chk("ack_irq_hold", 16'(bus.irq), 16'h0001);
        for (int t = 2 * P + 5; t < 3 * P; t++) tick(1'b1);
        chk("pre_wrap_irq", 16'(bus.irq), 16'h0001);
        // Acknowledge on the wrap tick: wrap wins and the full width follows.
        set_bus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00);
        tick(1'b1);
        chk("wrap_ack_irq", 16'(bus.irq), 16'h0000);
        idle();
        for (int t = 3 * P + 1; t <= 3 * P + W; t++) begin
            tick(1'b1);
            chk($sformatf("wrap_w_t%0d", t), 16'(bus.irq), (t < 3 * P + W) ? 16'h0000 : 16'h0001);
        end
        // Idle ticks with ne low must not advance anything.
        do_reset();
        for (int t = 0; t < 3 * P; t++) tick(1'b0);
        chk("ne_low_irq", 16'(bus.irq), 16'h0001);

        // Reset asserted mid-write while irq is low.
        do_reset();
        for (int t = 1; t <= P; t++) tick(1'b1);
        chk("pre_rst_irq", 16'(bus.irq), 16'h0000);
        set_bus(1'b0, 1'b1, 1'b1, 1'b0, 16'h007F, 8'hAA);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_irq", 16'(bus.irq), 16'h0001);
        chk("async_rst_bank", 16'(bank), 16'h0000);
        chk("async_rst_q", 16'(bus.q), 16'h00FF);
        tick(1'b1);
        chk("rst_hold_bank", 16'(bank), 16'h0000);

        // Random bus traffic against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic [7:0] port;
                case ($urandom_range(0, 2))
                    0: port = 8'h7F;
                    1: port = 8'h80;
                    default: port = 8'($urandom);
                endcase
                set_bus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        {8'($urandom), port}, 8'($urandom));
                kbd = 8'($urandom);
            end
            ne = ($urandom_range(0, 3) != 0);
            @(posedge clock);
            #1;
            if (ne) model_tick();
            chk("rnd_q", 16'(bus.q), 16'(m_q));
            chk("rnd_bank", 16'(bank), 16'(m_bank));
            chk("rnd_video", 16'(video), 16'(m_video));
            chk("rnd_irq", 16'(bus.irq), 16'(m_irq()));
            chk("rnd_row", 16'(kbd_row), 16'(bus.a[11:8]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
